// File: rtl/s_axi_write.sv
// rtl/s_axi_write.sv - AXI-lite write slave decoding into bank0 registers and bank1 slots (optional SLVERR via S_AXI_WRITE_SLVERR_EN)
module s_axi_write #(
    parameter int ADDR_WIDTH        = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int BANK1_INDEX_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,

    input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,

    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,

    output logic                         ext_bank0_wr_en,
    output logic [7:0]                   ext_bank0_wr_sel,
    output logic [DATA_WIDTH-1:0]        ext_bank0_wr_data,

    output logic                         ext_bank1_wr_en,
    output logic [BANK1_INDEX_WIDTH-1:0] ext_bank1_wr_index,
    output logic [3:0]                   ext_bank1_wr_field,
    output logic [DATA_WIDTH-1:0]        ext_bank1_wr_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_W = 3'd1,
        WAIT_A = 3'd2,
        COMMIT = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    bank0_wr_en_q;
    logic                    bank1_wr_en_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;

    logic                    aw_open, w_open;
    logic                    aw_hs, w_hs;
    logic                    commit_go;
    logic                    dec_bank0, dec_bank1, dec_slverr;

    // Strobes are ignored (full-word writes) and the low address bits never
    // take part in decode; fold them away so they are visibly unused.
    logic                    unused_bits;
    assign unused_bits = ^{S_AXI_WSTRB, addr_q[1:0]};

    // Each channel is open only while its half of the transaction is still
    // outstanding; this also blocks a second transaction until IDLE.
    assign aw_open = reset && (state_q == IDLE || state_q == WAIT_A);
    assign w_open  = reset && (state_q == IDLE || state_q == WAIT_W);

    assign S_AXI_AWREADY = S_AXI_AWVALID && aw_open;
    assign S_AXI_WREADY  = S_AXI_WVALID  && w_open;

    assign aw_hs = S_AXI_AWVALID && aw_open;
    assign w_hs  = S_AXI_WVALID  && w_open;

    // Commit is entered on the cycle that completes the second half.
    assign commit_go = (state_q == IDLE   && aw_hs && w_hs) ||
                       (state_q == WAIT_W && w_hs) ||
                       (state_q == WAIT_A && aw_hs);

    // Next value of the held address/data: capture on handshake, else hold.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (aw_hs) begin
            addr_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
            data_d = S_AXI_WDATA;
        end
    end

    // Decode the address that will be held during COMMIT into a target bank.
    always_comb begin
        dec_bank0  = 1'b0;
        dec_bank1  = 1'b0;
        dec_slverr = 1'b0;
        case (addr_d[15:14])
            2'b00:   dec_bank0 = 1'b1;
            2'b01:   dec_bank1 = 1'b1;
            default: dec_bank0 = 1'b0;
        endcase
`ifdef S_AXI_WRITE_SLVERR_EN
        if (addr_d[15]) begin
            dec_slverr = 1'b1;
        end
        if (dec_bank0 && addr_d[13:6] > 8'h08) begin
            dec_bank0  = 1'b0;
            dec_slverr = 1'b1;
        end
        if (dec_bank1 && addr_d[5:2] > 4'h8) begin
            dec_bank1  = 1'b0;
            dec_slverr = 1'b1;
        end
`endif
    end

    // Write FSM with registered strobes and response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            bank0_wr_en_q <= 1'b0;
            bank1_wr_en_q <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'b00;
        end else begin
            addr_q        <= addr_d;
            data_q        <= data_d;
            bank0_wr_en_q <= commit_go && dec_bank0;
            bank1_wr_en_q <= commit_go && dec_bank1;
            case (state_q)
                IDLE: begin
                    if (aw_hs && w_hs) begin
                        state_q <= COMMIT;
                    end else if (aw_hs) begin
                        state_q <= WAIT_W;
                    end else if (w_hs) begin
                        state_q <= WAIT_A;
                    end
                end
                WAIT_W: begin
                    if (w_hs) begin
                        state_q <= COMMIT;
                    end
                end
                WAIT_A: begin
                    if (aw_hs) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    state_q  <= RESP;
                    bvalid_q <= 1'b1;
                    bresp_q  <= dec_slverr ? 2'b10 : 2'b00;
                end
                RESP: begin
                    if (S_AXI_BREADY) begin
                        state_q  <= IDLE;
                        bvalid_q <= 1'b0;
                        bresp_q  <= 2'b00;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    bvalid_q      <= 1'b0;
                    bresp_q       <= 2'b00;
                    bank0_wr_en_q <= 1'b0;
                    bank1_wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;

    assign ext_bank0_wr_en   = bank0_wr_en_q;
    assign ext_bank0_wr_sel  = addr_q[13:6];
    assign ext_bank0_wr_data = data_q;

    assign ext_bank1_wr_en    = bank1_wr_en_q;
    assign ext_bank1_wr_index = addr_q[BANK1_INDEX_WIDTH+5:6];
    assign ext_bank1_wr_field = addr_q[5:2];
    assign ext_bank1_wr_data  = data_q;

endmodule

// File: tb/tb_s_axi_write.sv
// tb/tb_s_axi_write.sv - randomized self-checking bench for s_axi_write
module tb_s_axi_write;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int IW = 3;

    logic            clk;
    logic            reset;
    logic [AW-1:0]   S_AXI_AWADDR;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic            ext_bank0_wr_en;
    logic [7:0]      ext_bank0_wr_sel;
    logic [DW-1:0]   ext_bank0_wr_data;
    logic            ext_bank1_wr_en;
    logic [IW-1:0]   ext_bank1_wr_index;
    logic [3:0]      ext_bank1_wr_field;
    logic [DW-1:0]   ext_bank1_wr_data;

    int checks = 0;
    int errors = 0;

    s_axi_write #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK1_INDEX_WIDTH(IW)) dut (
        .clk                (clk),
        .reset              (reset),
        .S_AXI_AWADDR       (S_AXI_AWADDR),
        .S_AXI_AWVALID      (S_AXI_AWVALID),
        .S_AXI_AWREADY      (S_AXI_AWREADY),
        .S_AXI_WDATA        (S_AXI_WDATA),
        .S_AXI_WSTRB        (S_AXI_WSTRB),
        .S_AXI_WVALID       (S_AXI_WVALID),
        .S_AXI_WREADY       (S_AXI_WREADY),
        .S_AXI_BRESP        (S_AXI_BRESP),
        .S_AXI_BVALID       (S_AXI_BVALID),
        .S_AXI_BREADY       (S_AXI_BREADY),
        .ext_bank0_wr_en    (ext_bank0_wr_en),
        .ext_bank0_wr_sel   (ext_bank0_wr_sel),
        .ext_bank0_wr_data  (ext_bank0_wr_data),
        .ext_bank1_wr_en    (ext_bank1_wr_en),
        .ext_bank1_wr_index (ext_bank1_wr_index),
        .ext_bank1_wr_field (ext_bank1_wr_field),
        .ext_bank1_wr_data  (ext_bank1_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full write transaction: AW and W offered after independent delays,
    // BREADY raised b_dly cycles after BVALID is due. Every cycle is checked
    // against what the protocol rules say should be visible.
    task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input string name);
        int         exp_bank;
        logic [7:0] exp_sel;
        logic [2:0] exp_idx;
        logic [3:0] exp_field;
        logic [1:0] exp_resp;
        bit         aw_done, w_done, b_done;
        int         hs, cyc;
        logic       exp_b0, exp_b1, exp_bv;

        exp_sel   = 8'((addr >> 6) & 16'hFF);
        exp_idx   = 3'((addr >> 6) & 16'h7);
        exp_field = 4'((addr >> 2) & 16'hF);
        exp_resp  = 2'b00;
        if (addr / 16'h4000 == 0)      exp_bank = 0;
        else if (addr / 16'h4000 == 1) exp_bank = 1;
        else                           exp_bank = -1;
`ifdef S_AXI_WRITE_SLVERR_EN
        if (exp_bank == -1 || (exp_bank == 0 && exp_sel > 8) ||
            (exp_bank == 1 && exp_field > 8)) begin
            exp_bank = -1;
            exp_resp = 2'b10;
        end
`endif
        aw_done = 0; w_done = 0; b_done = 0; hs = 0; cyc = 0;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = 4'($urandom);
        while (!b_done && cyc < 200) begin
            @(negedge clk);
            if (!aw_done) S_AXI_AWVALID = (cyc >= aw_dly);
            else begin
                S_AXI_AWVALID = 1'($urandom_range(0, 1));
                S_AXI_AWADDR  = 16'($urandom);
            end
            if (!w_done) S_AXI_WVALID = (cyc >= w_dly);
            else begin
                S_AXI_WVALID = 1'($urandom_range(0, 1));
                S_AXI_WDATA  = $urandom;
            end
            S_AXI_BREADY = aw_done && w_done && (cyc >= hs + 2 + b_dly);
            #1;
            checks++;
            if (S_AXI_AWREADY !== (aw_done ? 1'b0 : S_AXI_AWVALID)) begin
                errors++;
                $display("FAIL %s awready cyc=%0d got=%b exp=%b", name, cyc, S_AXI_AWREADY, aw_done ? 1'b0 : S_AXI_AWVALID);
            end
            checks++;
            if (S_AXI_WREADY !== (w_done ? 1'b0 : S_AXI_WVALID)) begin
                errors++;
                $display("FAIL %s wready cyc=%0d got=%b exp=%b", name, cyc, S_AXI_WREADY, w_done ? 1'b0 : S_AXI_WVALID);
            end
            exp_bv = aw_done && w_done && (cyc >= hs + 2);
            exp_b0 = aw_done && w_done && (cyc == hs + 1) && (exp_bank == 0);
            exp_b1 = aw_done && w_done && (cyc == hs + 1) && (exp_bank == 1);
            checks++;
            if (S_AXI_BVALID !== exp_bv) begin
                errors++;
                $display("FAIL %s bvalid cyc=%0d got=%b exp=%b", name, cyc, S_AXI_BVALID, exp_bv);
            end
            checks++;
            if (ext_bank0_wr_en !== exp_b0 || ext_bank1_wr_en !== exp_b1) begin
                errors++;
                $display("FAIL %s wr_en cyc=%0d got=%b%b exp=%b%b", name, cyc, ext_bank0_wr_en, ext_bank1_wr_en, exp_b0, exp_b1);
            end
            if (exp_b0) begin
                checks++;
                if (ext_bank0_wr_sel !== exp_sel || ext_bank0_wr_data !== data) begin
                    errors++;
                    $display("FAIL %s bank0 sel/data got=%h/%h exp=%h/%h", name, ext_bank0_wr_sel, ext_bank0_wr_data, exp_sel, data);
                end
            end
            if (exp_b1) begin
                checks++;
                if (ext_bank1_wr_index !== exp_idx || ext_bank1_wr_field !== exp_field || ext_bank1_wr_data !== data) begin
                    errors++;
                    $display("FAIL %s bank1 idx/field/data got=%h/%h/%h exp=%h/%h/%h", name, ext_bank1_wr_index, ext_bank1_wr_field, ext_bank1_wr_data, exp_idx, exp_field, data);
                end
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                b_done = 1;
                checks++;
                if (S_AXI_BRESP !== exp_resp) begin
                    errors++;
                    $display("FAIL %s bresp got=%b exp=%b", name, S_AXI_BRESP, exp_resp);
                end
            end
            if (!(aw_done && w_done)) begin
                if (!aw_done && S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
                if (!w_done && S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
                if (aw_done && w_done) hs = cyc;
            end
            cyc++;
        end
        checks++;
        if (!b_done) begin
            errors++;
            $display("FAIL %s timeout got=no_bresp exp=bresp_within_200", name);
        end
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        #1;
        checks++;
        if (S_AXI_BVALID !== 1'b0 || ext_bank0_wr_en !== 1'b0 || ext_bank1_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after got=bv%b en%b%b exp=0", name, S_AXI_BVALID, ext_bank0_wr_en, ext_bank1_wr_en);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        S_AXI_AWADDR = 16'h4088; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0 || S_AXI_BVALID !== 1'b0 ||
            S_AXI_BRESP !== 2'b00 || ext_bank0_wr_en !== 1'b0 || ext_bank1_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b%b%b%b%b exp=000000", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, ext_bank0_wr_en, ext_bank1_wr_en);
        end
        checks++;
        if (ext_bank0_wr_sel !== 8'h00 || ext_bank0_wr_data !== 32'h0 || ext_bank1_wr_field !== 4'h0 || ext_bank1_wr_index !== 3'h0) begin
            errors++;
            $display("FAIL reset_held got=%h/%h/%h/%h exp=0", ext_bank0_wr_sel, ext_bank0_wr_data, ext_bank1_wr_index, ext_bank1_wr_field);
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_same_cycle();
        do_write(16'h0040, 32'h1234_5678, 0, 0, 0, "same_cycle");
    endtask

    task automatic test_w_first();
        do_write(16'h4088, 32'hCAFE_F00D, 3, 0, 0, "w_first");
    endtask

    task automatic test_bready_stall();
        do_write(16'h0080, $urandom, 0, 0, 5, "bready_stall");
        do_write(16'h4004, $urandom, 2, 0, 5, "bready_stall_aw_late");
    endtask

    task automatic test_unmapped();
        do_write(16'h8000, $urandom, 0, 0, 0, "unmapped_8000");
        do_write(16'hC0FC, $urandom, 1, 0, 2, "unmapped_c0fc");
        do_write(16'h0200, $urandom, 0, 0, 0, "bank0_sel08");
        do_write(16'h0240, $urandom, 0, 0, 0, "bank0_sel09");
        do_write(16'h4020, $urandom, 0, 0, 0, "bank1_field8");
        do_write(16'h4024, $urandom, 0, 0, 0, "bank1_field9");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        S_AXI_AWADDR = 16'h0040; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0;
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        #1;
        checks++;
        if (S_AXI_AWREADY !== 1'b0 || ext_bank0_wr_sel !== 8'h01) begin
            errors++;
            $display("FAIL reset_mid_wait_w got=awready%b sel%h exp=awready0 sel01", S_AXI_AWREADY, ext_bank0_wr_sel);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (S_AXI_BVALID !== 1'b0 || ext_bank0_wr_en !== 1'b0 || ext_bank1_wr_en !== 1'b0 || ext_bank0_wr_sel !== 8'h00) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d got=bv%b en%b%b sel%h exp=0", i, S_AXI_BVALID, ext_bank0_wr_en, ext_bank1_wr_en, ext_bank0_wr_sel);
            end
        end
        do_write(16'h0100, $urandom, 0, 0, 0, "reset_mid_recover");
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 4))
                0: a[15:14] = 2'b00;
                1: a[15:14] = 2'b01;
                2: begin a[15:14] = 2'b00; a[13:6] = 8'($urandom_range(7, 9)); end
                3: begin a[15:14] = 2'b01; a[5:2] = 4'($urandom_range(7, 9)); end
                default: a = a;
            endcase
            do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            do_write(16'($urandom), $urandom, 0, 0, 0, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_first();
        test_bready_stall();
        test_unmapped();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_axi_write.md
S_AXI_WRITE -- requirements
Module: s_axi_write

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, AXI-lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI-lite data width.
REQ-003 SHALL have parameter BANK1_INDEX_WIDTH, default 3, bank1 slot index width.
REQ-004 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port S_AXI_AWADDR, input, ADDR_WIDTH, write address.
REQ-007 SHALL have ports S_AXI_AWVALID (input, 1) and S_AXI_AWREADY (output, 1), write-address handshake.
REQ-008 SHALL have port S_AXI_WDATA, input, DATA_WIDTH, write data.
REQ-009 SHALL have port S_AXI_WSTRB, input, DATA_WIDTH/8, byte strobes; accepted but ignored, and every write SHALL be full-word.
REQ-010 SHALL have ports S_AXI_WVALID (input, 1) and S_AXI_WREADY (output, 1), write-data handshake.
REQ-011 SHALL have ports S_AXI_BRESP (output, 2), S_AXI_BVALID (output, 1) and S_AXI_BREADY (input, 1), write-response channel.
REQ-012 SHALL have ports ext_bank0_wr_en (output, 1), ext_bank0_wr_sel (output, 8) and ext_bank0_wr_data (output, DATA_WIDTH), bank0 register write strobe, select and data.
REQ-013 SHALL have ports ext_bank1_wr_en (output, 1), ext_bank1_wr_index (output, BANK1_INDEX_WIDTH), ext_bank1_wr_field (output, 4) and ext_bank1_wr_data (output, DATA_WIDTH), bank1 slot write strobe, index, field and data.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_W (address held), WAIT_A (data held), COMMIT and RESP.
REQ-015 S_AXI_AWREADY SHALL equal S_AXI_AWVALID when state is IDLE or WAIT_A, and 0 otherwise.
REQ-016 S_AXI_WREADY SHALL equal S_AXI_WVALID when state is IDLE or WAIT_W, and 0 otherwise.
REQ-017 Transitions from IDLE: AW and W together -> COMMIT; AW only -> WAIT_W; W only -> WAIT_A.
REQ-018 WAIT_W SHALL go to COMMIT on W, and WAIT_A SHALL go to COMMIT on AW; each state SHALL otherwise hold.
REQ-019 Accepted address and data SHALL be registered on their handshake cycle and held until return to IDLE.
REQ-020 COMMIT SHALL last exactly one cycle, assert the decoded wr_en for that cycle only, then go to RESP.
REQ-021 Decode rule: addr[15:14]=00 -> bank0 with wr_sel=addr[13:6].
REQ-022 Decode rule: addr[15:14]=01 -> bank1 with wr_index=addr[BANK1_INDEX_WIDTH+5:6] and wr_field=addr[5:2].
REQ-023 Decode rule: addr[15:14]=10 or 11 -> no wr_en is asserted, and the response is still issued.
REQ-024 wr_sel, wr_index, wr_field and wr_data SHALL be driven from the held registers and be stable throughout COMMIT.
REQ-025 In RESP, S_AXI_BVALID SHALL be 1 and held until S_AXI_BREADY; on BREADY the FSM SHALL go to IDLE.
REQ-026 Latency from the later of the AW/W handshakes to BVALID SHALL be 2 cycles.
REQ-027 No new AW or W SHALL be accepted from COMMIT until IDLE is re-entered, giving one outstanding transaction maximum.
REQ-028 S_AXI_BRESP SHALL be 2'b00 unless REQ-033 applies.
REQ-029 The default FSM branch SHALL recover to IDLE.

Reset
REQ-030 While reset=0: state=IDLE; BVALID, AWREADY, WREADY, both wr_en and BRESP SHALL be 0; held address and data registers SHALL be 0.
REQ-031 A reset asserted mid-transaction SHALL discard it: no wr_en and no response afterward.

Configuration
REQ-032 Macro S_AXI_WRITE_SLVERR_EN SHALL select the response-error feature.
REQ-033 With S_AXI_WRITE_SLVERR_EN defined, BRESP SHALL be 2'b10 for unmapped writes: addr[15:14]>=10, bank0 wr_sel>8'h08, or bank1 wr_field>4'h8; no wr_en is asserted for these. Without it, BRESP SHALL always be 2'b00 and bank0/bank1 strobes SHALL fire for every in-bank address.

Verification
REQ-034 AW=0x0040 and W=0x12345678 in the same cycle, BREADY=1 -> ext_bank0_wr_en pulse with sel=0x01, data=0x12345678; BVALID 2 cycles later, BRESP=00.
REQ-035 W=0xCAFEF00D first, AW=0x4088 three cycles later -> bank1 wr_en with index=2, field=2, data=0xCAFEF00D; WREADY=0 while in WAIT_A.
REQ-036 BREADY held 0 for 5 cycles -> BVALID stays 1, AWREADY=WREADY=0, a second AW is not accepted until after the BREADY handshake.
REQ-037 AW=0x8000 -> no wr_en; BRESP=10 with S_AXI_WRITE_SLVERR_EN defined, 00 without it.
REQ-038 reset pulled low while in WAIT_W -> IDLE, no wr_en and no BVALID after release; a subsequent AW+W completes normally.
